rs_berlekamp_massey: RTL and testbench

RS_BERLEKAMP_MASSEY -- requirements
Module: rs_berlekamp_massey

---
 rtl/gf_pkg.sv | 48 ++++
 rtl/rs_bm_discrepancy.sv | 49 ++++
 rtl/rs_berlekamp_massey.sv | 164 ++++++++++++++++
 tb/tb_rs_berlekamp_massey.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg
// Shared GF(2^m) definitions for the Reed-Solomon decoder blocks:
//   SYMB_WIDTH : symbol width m
//   ROOTS_NUM  : number of syndromes (2T)
//   T_LEN      : correction capability T
//   PRIM_POLY  : field generator polynomial (x^8+x^4+x^3+x^2+1)
//   bm_state_e : control states of the Berlekamp-Massey engine
//   gf_mult    : combinational GF(2^m) multiply
// ---------------------------------------------------------------------------
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int ROOTS_NUM  = 4;
  localparam int T_LEN      = ROOTS_NUM / 2;

  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    BM_IDLE = 2'd0,
    BM_CALC = 2'd1,
    BM_DONE = 2'd2
  } bm_state_e;

  // Shift-and-add multiply; the partial multiplicand is reduced by the
  // generator each time it overflows bit m-1.
  function automatic logic [SYMB_WIDTH-1:0] gf_mult(
    input logic [SYMB_WIDTH-1:0] a,
    input logic [SYMB_WIDTH-1:0] b
  );
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end
      if (sh[SYMB_WIDTH-1]) begin
        sh = (sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
      end else begin
        sh = sh << 1;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_bm_discrepancy.sv
// ---------------------------------------------------------------------------
// rs_bm_discrepancy
// Combinational discrepancy for one Berlekamp-Massey iteration:
//   delta = XOR_{i=0..L, i<=r} Lambda_i * S(r-i)
// Ports:
//   lambda_i : Lambda coefficients 0..ROOTS_NUM-1 (higher ones can never
//              pair with a syndrome since r <= ROOTS_NUM-1)
//   synd_i   : syndromes S0..S(ROOTS_NUM-1)
//   r_i      : current iteration index
//   deg_i    : current locator length L
//   delta_o  : discrepancy
// ---------------------------------------------------------------------------
module rs_bm_discrepancy
  import gf_pkg::gf_mult;
#(
  parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
  parameter int ROOTS_NUM  = gf_pkg::ROOTS_NUM
) (
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] lambda_i,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] synd_i,
  input  logic [$clog2(ROOTS_NUM+1)-1:0]       r_i,
  input  logic [$clog2(ROOTS_NUM+1)-1:0]       deg_i,
  output logic [SYMB_WIDTH-1:0]                delta_o
);

  localparam int CNT_W = $clog2(ROOTS_NUM + 1);
  localparam int SEL_W = (ROOTS_NUM > 1) ? $clog2(ROOTS_NUM) : 1;

  logic [SYMB_WIDTH-1:0] term [ROOTS_NUM];

  generate
    for (genvar gi = 0; gi < ROOTS_NUM; gi++) begin : g_term
      logic [SEL_W-1:0] sel;
      logic             use_term;
      // Syndrome index r-i; only meaningful when use_term is set.
      assign sel      = SEL_W'(r_i - CNT_W'(gi));
      assign use_term = (CNT_W'(gi) <= r_i) && (CNT_W'(gi) <= deg_i);
      assign term[gi] = use_term ? gf_mult(lambda_i[gi], synd_i[sel]) : '0;
    end
  endgenerate

  always_comb begin
    delta_o = '0;
    for (int i = 0; i < ROOTS_NUM; i++) begin
      delta_o = delta_o ^ term[i];
    end
  end

endmodule

// File: rtl/rs_berlekamp_massey.sv
// ---------------------------------------------------------------------------
// rs_berlekamp_massey
// Inversionless Berlekamp-Massey: turns 2T syndromes into the error locator
// polynomial Lambda(x), one iteration per clock.
// Ports:
//   aclk, aresetn     : clock, asynchronous active-low reset
//   s_tvalid/s_tready : syndrome vector handshake, s_tdata = S0..S(2T-1)
//   m_tvalid/m_tready : result handshake
//   m_tdata           : Lambda[T_LEN:0] (index = power of x, not monic)
//   m_deg             : locator length L
//   m_fail            : L > T_LEN, word uncorrectable
// Build option:
//   RS_BM_ZERO_SKIP_EN : an all-zero syndrome vector goes straight to DONE
//                        with Lambda = 1 instead of iterating.
// ---------------------------------------------------------------------------
module rs_berlekamp_massey
  import gf_pkg::gf_mult, gf_pkg::bm_state_e, gf_pkg::BM_IDLE,
         gf_pkg::BM_CALC, gf_pkg::BM_DONE;
#(
  parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
  parameter int ROOTS_NUM  = gf_pkg::ROOTS_NUM
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]   s_tdata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [ROOTS_NUM/2:0][SYMB_WIDTH-1:0]   m_tdata,
  output logic [$clog2(ROOTS_NUM+1)-1:0]         m_deg,
  output logic                                   m_fail
);

  localparam int T_LEN = ROOTS_NUM / 2;
  localparam int CNT_W = $clog2(ROOTS_NUM + 1);

  localparam logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] POLY_ONE =
    {{(ROOTS_NUM*SYMB_WIDTH){1'b0}}, SYMB_WIDTH'(1)};

  bm_state_e                               state_q;
  logic                                    s_tready_q;
  logic                                    m_tvalid_q;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]    synd_q;
  logic [ROOTS_NUM:0][SYMB_WIDTH-1:0]      lambda_q;
  logic [ROOTS_NUM:0][SYMB_WIDTH-1:0]      lambda_d;
  logic [ROOTS_NUM:0][SYMB_WIDTH-1:0]      b_q;
  logic [ROOTS_NUM:0][SYMB_WIDTH-1:0]      xb_d;
  logic [SYMB_WIDTH-1:0]                   gamma_q;
  logic [SYMB_WIDTH-1:0]                   delta;
  logic [CNT_W-1:0]                        l_q;
  logic [CNT_W-1:0]                        r_q;
  logic                                    swap;
  logic                                    b_top_unused;

  rs_bm_discrepancy #(
    .SYMB_WIDTH (SYMB_WIDTH),
    .ROOTS_NUM  (ROOTS_NUM)
  ) u_disc (
    .lambda_i (lambda_q[ROOTS_NUM-1:0]),
    .synd_i   (synd_q),
    .r_i      (r_q),
    .deg_i    (l_q),
    .delta_o  (delta)
  );

  // Lambda' = gamma*Lambda + delta*x*B, and the shifted B for the hold case.
  // Whatever would move past x^ROOTS_NUM is simply dropped.
  generate
    for (genvar gi = 0; gi <= ROOTS_NUM; gi++) begin : g_coef
      if (gi == 0) begin : g_c0
        assign xb_d[gi]     = '0;
        assign lambda_d[gi] = gf_mult(gamma_q, lambda_q[gi]);
      end else begin : g_cn
        assign xb_d[gi]     = b_q[gi-1];
        assign lambda_d[gi] = gf_mult(gamma_q, lambda_q[gi]) ^
                              gf_mult(delta, b_q[gi-1]);
      end
    end
  endgenerate

  // The top B coefficient is kept for completeness but can only be shifted out.
  assign b_top_unused = ^b_q[ROOTS_NUM];

  // Length change when the discrepancy is non-zero and 2L <= r.
  assign swap = (delta != '0) && ({l_q, 1'b0} <= {1'b0, r_q});

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= BM_IDLE;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      synd_q     <= '0;
      lambda_q   <= '0;
      b_q        <= '0;
      gamma_q    <= '0;
      l_q        <= '0;
      r_q        <= '0;
    end else begin
      case (state_q)
        BM_IDLE: begin
          s_tready_q <= 1'b1;
          if (s_tvalid && s_tready_q) begin
            s_tready_q <= 1'b0;
            synd_q     <= s_tdata;
            lambda_q   <= POLY_ONE;
            b_q        <= POLY_ONE;
            gamma_q    <= SYMB_WIDTH'(1);
            l_q        <= '0;
            r_q        <= '0;
`ifdef RS_BM_ZERO_SKIP_EN
            // Zero syndromes mean no errors: the initial Lambda=1 is final.
            if (s_tdata == '0) begin
              state_q    <= BM_DONE;
              m_tvalid_q <= 1'b1;
            end else begin
              state_q <= BM_CALC;
            end
`else
            state_q <= BM_CALC;
`endif
          end
        end

        BM_CALC: begin
          lambda_q <= lambda_d;
          r_q      <= r_q + CNT_W'(1);
          if (swap) begin
            b_q     <= lambda_q;
            l_q     <= r_q + CNT_W'(1) - l_q;
            gamma_q <= delta;
          end else begin
            b_q <= xb_d;
          end
          if (r_q == CNT_W'(ROOTS_NUM - 1)) begin
            state_q    <= BM_DONE;
            m_tvalid_q <= 1'b1;
          end
        end

        BM_DONE: begin
          if (m_tready) begin
            state_q    <= BM_IDLE;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= BM_IDLE;
          m_tvalid_q <= 1'b0;
          s_tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = lambda_q[T_LEN:0];
  assign m_deg    = l_q;
  assign m_fail   = (l_q > CNT_W'(T_LEN));

endmodule

// File: tb/tb_rs_berlekamp_massey.sv
// ---------------------------------------------------------------------------
// tb_rs_berlekamp_massey
// Directed bench for the Berlekamp-Massey block, GF(2^8)/0x11D, 2T = 4.
// Expected locators were worked out by hand from the syndrome tables below.
// ---------------------------------------------------------------------------
module tb_rs_berlekamp_massey;

  logic              aclk;
  logic              aresetn;
  logic              s_tvalid;
  logic              s_tready;
  logic [3:0][7:0]   s_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [2:0][7:0]   m_tdata;
  logic [2:0]        m_deg;
  logic              m_fail;

  int n_vec = 0;
  int n_err = 0;

`ifdef RS_BM_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 5;
`endif

  // Syndromes packed {S3,S2,S1,S0}; locators packed {L2,L1,L0}.
  localparam logic [31:0] V_ALPHA  = 32'h08040201;  // Y=1,    X=alpha
  localparam logic [23:0] E_ALPHA  = 24'h000201;
  localparam logic [31:0] V_SCALED = 32'h180C0603;  // Y=3,    X=alpha
  localparam logic [23:0] E_SCALED = 24'h001E0F;
  localparam logic [31:0] V_HIGH   = 32'h75138001;  // Y=1,    X=alpha^7
  localparam logic [23:0] E_HIGH   = 24'h008001;
  localparam logic [31:0] V_FAIL   = 32'h01000000;
  localparam logic [23:0] E_ONE    = 24'h000001;

  rs_berlekamp_massey dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_deg    (m_deg),
    .m_fail   (m_fail)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Offer one vector, then count cycles from the accept cycle (=0) until
  // m_tvalid is seen; gives up after 50 cycles.
  task automatic send_vec(input logic [31:0] v, output int lat);
    int guard;
    guard = 0;
    while (!s_tready && guard < 50) begin
      @(posedge aclk); #1;
      guard++;
    end
    s_tdata  = v;
    s_tvalid = 1'b1;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 50) begin
      @(posedge aclk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    m_tready = 1'b1;
    @(posedge aclk); #1;
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 24'h0 ||
        m_deg !== 3'd0 || m_fail !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h deg=%0d fail=%b required 0/0/000000/0/0",
               s_tready, m_tvalid, m_tdata, m_deg, m_fail);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_vec++;
    if (s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got s_tready=%b required 1", s_tready);
    end
    $display("reset: released, s_tready=%b", s_tready);
  endtask

  task automatic test_single_error(input string name, input logic [31:0] v,
                                   input logic [23:0] exp_data);
    int lat;
    send_vec(v, lat);
    $display("vec %s: S=%h lambda=%h deg=%0d fail=%b lat=%0d", name, v, m_tdata, m_deg, m_fail, lat);
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL %s_latency: got %0d required 5", name, lat);
    end
    n_vec++;
    if (m_tdata !== exp_data) begin
      n_err++;
      $display("FAIL %s_lambda: got %h required %h", name, m_tdata, exp_data);
    end
    n_vec++;
    if (m_deg !== 3'd1 || m_fail !== 1'b0) begin
      n_err++;
      $display("FAIL %s_deg: got deg=%0d fail=%b required deg=1 fail=0", name, m_deg, m_fail);
    end
    release_result();
  endtask

  task automatic test_zero();
    int lat;
    send_vec(32'h0, lat);
    $display("vec zero: S=00000000 lambda=%h deg=%0d fail=%b lat=%0d", m_tdata, m_deg, m_fail, lat);
    n_vec++;
    if (lat !== ZERO_LAT) begin
      n_err++;
      $display("FAIL zero_latency: got %0d required %0d", lat, ZERO_LAT);
    end
    n_vec++;
    if (m_tdata !== E_ONE || m_deg !== 3'd0 || m_fail !== 1'b0) begin
      n_err++;
      $display("FAIL zero_result: got %h/%0d/%b required %h/0/0", m_tdata, m_deg, m_fail, E_ONE);
    end
    release_result();
  endtask

  task automatic test_uncorrectable();
    int lat;
    send_vec(V_FAIL, lat);
    $display("vec uncorr: S=%h lambda=%h deg=%0d fail=%b lat=%0d", V_FAIL, m_tdata, m_deg, m_fail, lat);
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL uncorr_latency: got %0d required 5", lat);
    end
    n_vec++;
    if (m_tdata !== E_ONE || m_deg !== 3'd4 || m_fail !== 1'b1) begin
      n_err++;
      $display("FAIL uncorr_result: got %h/%0d/%b required %h/4/1", m_tdata, m_deg, m_fail, E_ONE);
    end
    release_result();
  endtask

  task automatic test_stall();
    int lat;
    send_vec(V_ALPHA, lat);
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL stall_latency: got %0d required 5", lat);
    end
    // A competing vector offered during DONE must be ignored.
    s_tdata  = 32'hFFFFFFFF;
    s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      n_vec++;
      if (m_tvalid !== 1'b1 || s_tready !== 1'b0 || m_tdata !== E_ALPHA ||
          m_deg !== 3'd1 || m_fail !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got vld=%b rdy=%b data=%h deg=%0d fail=%b required 1/0/%h/1/0",
                 i, m_tvalid, s_tready, m_tdata, m_deg, m_fail, E_ALPHA);
      end
    end
    s_tvalid = 1'b0;
    release_result();
    n_vec++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_handshake: got vld=%b rdy=%b required 0/1", m_tvalid, s_tready);
    end
    @(posedge aclk); #1;
    n_vec++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_single: got vld=%b rdy=%b required 0/1", m_tvalid, s_tready);
    end
    $display("stall: held 10 cycles, one transfer, lambda=%h", E_ALPHA);
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int guard;
    guard = 0;
    while (!s_tready && guard < 50) begin
      @(posedge aclk); #1;
      guard++;
    end
    s_tdata  = V_SCALED;
    s_tvalid = 1'b1;
    @(posedge aclk); #1;          // accepted, iteration 0
    s_tvalid = 1'b0;
    @(posedge aclk); #1;          // iteration 1
    @(posedge aclk); #1;          // iteration 2
    aresetn = 1'b0;
    #1;
    n_vec++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 24'h0 ||
        m_deg !== 3'd0 || m_fail !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state: got rdy=%b vld=%b data=%h deg=%0d fail=%b required 0/0/000000/0/0",
               s_tready, m_tvalid, m_tdata, m_deg, m_fail);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    send_vec(V_ALPHA, lat);
    $display("vec after_reset: S=%h lambda=%h deg=%0d lat=%0d", V_ALPHA, m_tdata, m_deg, lat);
    n_vec++;
    if (lat !== 5 || m_tdata !== E_ALPHA || m_deg !== 3'd1 || m_fail !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_next: got lat=%0d data=%h deg=%0d fail=%b required 5/%h/1/0",
               lat, m_tdata, m_deg, m_fail, E_ALPHA);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    int guard;
    m_tready = 1'b1;
    guard = 0;
    while (!s_tready && guard < 50) begin
      @(posedge aclk); #1;
      guard++;
    end
    s_tdata  = V_SCALED;
    s_tvalid = 1'b1;
    @(posedge aclk); #1;          // first vector accepted
    s_tdata = V_HIGH;             // second vector waits on s_tvalid
    lat = 1;
    while (!m_tvalid && lat < 50) begin
      @(posedge aclk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 5 || m_tdata !== E_SCALED) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d data=%h required 5/%h", lat, m_tdata, E_SCALED);
    end
    $display("vec b2b_first: S=%h lambda=%h lat=%0d", V_SCALED, m_tdata, lat);
    @(posedge aclk); #1;          // result handshake
    n_vec++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_handshake: got vld=%b rdy=%b required 0/1", m_tvalid, s_tready);
    end
    @(posedge aclk); #1;          // second accept, one cycle after handshake
    s_tvalid = 1'b0;
    n_vec++;
    if (s_tready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got s_tready=%b required 0", s_tready);
    end
    lat = 1;
    while (!m_tvalid && lat < 50) begin
      @(posedge aclk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 5 || m_tdata !== E_HIGH || m_deg !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d data=%h deg=%0d required 5/%h/1", lat, m_tdata, m_deg, E_HIGH);
    end
    $display("vec b2b_second: S=%h lambda=%h lat=%0d", V_HIGH, m_tdata, lat);
    @(posedge aclk); #1;
    m_tready = 1'b0;
    n_vec++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got m_tvalid=%b required 0", m_tvalid);
    end
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    test_reset();
    test_single_error("alpha", V_ALPHA, E_ALPHA);
    test_single_error("scaled", V_SCALED, E_SCALED);
    test_single_error("alpha7", V_HIGH, E_HIGH);
    test_zero();
    test_uncorrectable();
    test_stall();
    test_reset_mid_calc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
